// File: rtl/game_ctrl.sv
// Game sequencer: turns player buttons and a gravity timer into one-cycle move requests for
// the field stage, picks each new piece from an LFSR, and keeps score and level until gameover.
module game_ctrl #(
    parameter logic [23:0] GRAV_TICKS = 24'd5_000_000,
    parameter logic [23:0] GRAV_STEP  = 24'd400_000,
    parameter logic [23:0] GRAV_MIN   = 24'd500_000,
    parameter logic [15:0] LEVEL_PTS  = 16'd100,
    parameter logic [3:0]  MAX_LEVEL  = 4'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_down,
    input  logic        btn_rot,
    input  logic        next_block,
    input  logic [9:0]  score_plus,
    input  logic        gameover,
    output logic [9:0]  block_num,
    output logic        left,
    output logic        right,
    output logic        down,
    output logic [9:0]  ro,
    output logic [15:0] score,
    output logic [3:0]  level,
    output logic        playing
);

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_FALL, S_OVER} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [23:0] grav_cnt;
    logic [15:0] lvl_acc;
    logic        start_prev;
    logic [3:0]  btn_prev;          // bit order {down, rot, left, right} for all 4-bit vectors
    logic [3:0]  pend, pend_nxt;
    logic [3:0]  req, want;

    logic [3:0]  btn, btn_rise;
    logic        start_rise, in_fall, can_issue, landing, grav_due;
    logic [27:0] grav_cut;
    logic [23:0] period;
    logic [16:0] score_sum, acc_sum, acc_left;
    logic        acc_wrap;

    assign btn        = {btn_down, btn_rot, btn_left, btn_right};
    assign btn_rise   = btn & ~btn_prev;
    assign start_rise = start & ~start_prev;
    assign in_fall    = (state == S_FALL);
    assign can_issue  = in_fall && !next_block && !gameover;
    assign landing    = in_fall && next_block && !gameover;

    // Compare before subtracting so high levels clamp to GRAV_MIN instead of wrapping.
    always_comb begin
        // NOTE: each signal written here gets a default first, so no path infers a latch.
        grav_cut = 28'(level) * 28'(GRAV_STEP);
        period   = GRAV_MIN;
        if (grav_cut < 28'(GRAV_TICKS) && (GRAV_TICKS - grav_cut[23:0]) > GRAV_MIN)
            period = GRAV_TICKS - grav_cut[23:0];
    end

    assign grav_due = in_fall && (grav_cnt >= period - 24'd1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_rise) state_nxt = S_SPAWN;
            S_SPAWN: state_nxt = gameover ? S_OVER : S_FALL;
            S_FALL:  if (gameover) state_nxt = S_OVER;
                     else if (next_block) state_nxt = S_SPAWN;
            S_OVER:  if (start_rise) state_nxt = S_SPAWN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One request per cycle; whatever loses arbitration stays pending for a later cycle.
    always_comb begin
        req      = 4'b0000;
        pend_nxt = 4'b0000;
        want     = pend | btn_rise | {grav_due, 3'b000};
        if (can_issue) begin
            if (want[3])      req = 4'b1000;
            else if (want[2]) req = 4'b0100;
            else if (want[1]) req = 4'b0010;
            else if (want[0]) req = 4'b0001;
            pend_nxt = (pend | btn_rise) & ~req;
        end
    end

    always_comb begin
        score_sum = {1'b0, score} + {7'd0, score_plus};
        acc_sum   = {1'b0, lvl_acc} + {7'd0, score_plus};
        acc_wrap  = (acc_sum >= {1'b0, LEVEL_PTS});
        acc_left  = acc_wrap ? acc_sum - {1'b0, LEVEL_PTS} : acc_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lfsr       <= 16'hACE1;
            grav_cnt   <= 24'd0;
            lvl_acc    <= 16'd0;
            start_prev <= 1'b0;
            btn_prev   <= 4'b0000;
            pend       <= 4'b0000;
            block_num  <= 10'd0;
            left       <= 1'b0;
            right      <= 1'b0;
            down       <= 1'b0;
            ro         <= 10'd0;
            score      <= 16'd0;
            level      <= 4'd0;
            playing    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            start_prev <= start;
            btn_prev   <= btn;
            state      <= state_nxt;
            playing    <= (state_nxt == S_SPAWN) || (state_nxt == S_FALL);
            pend       <= pend_nxt;
            down       <= req[3];
            ro         <= {9'd0, req[2]};
            left       <= req[1];
            right      <= req[0];

            if (state == S_SPAWN) begin
                block_num <= {7'd0, (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0]};
                grav_cnt  <= 24'd0;
            end else if (in_fall) begin
                grav_cnt  <= grav_due ? 24'd0 : grav_cnt + 24'd1;
            end

            if (start_rise && (state == S_IDLE || state == S_OVER)) begin
                score   <= 16'd0;
                level   <= 4'd0;
                lvl_acc <= 16'd0;
            end else if (landing) begin
                score   <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                lvl_acc <= acc_left[16] ? 16'hFFFF : acc_left[15:0];
                if (acc_wrap && level < MAX_LEVEL)
                    level <= level + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected requests (cycle + kind), a
// negedge monitor pops and compares every request pulse the DUT presents.
module tb_game_ctrl;

    localparam logic [3:0] K_DOWN  = 4'b1000;
    localparam logic [3:0] K_ROT   = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b0010;
    localparam logic [3:0] K_RIGHT = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, btn_left, btn_right, btn_down, btn_rot;
    logic        next_block, gameover;
    logic [9:0]  score_plus;
    logic [9:0]  block_num, ro;
    logic        left, right, down, playing;
    logic [15:0] score;
    logic [3:0]  level;

    int   cyc = 0;
    int   fs = 0;
    int   per = 10;
    int   total = 0;
    int   bad = 0;
    int   ptab [10] = '{10, 8, 6, 4, 3, 3, 3, 3, 3, 3};
    exp_t exp_q [$];
    exp_t mon_e;
    logic [3:0] mon_obs;

    game_ctrl #(
        .GRAV_TICKS(24'd10),
        .GRAV_STEP (24'd2),
        .GRAV_MIN  (24'd3),
        .LEVEL_PTS (16'd100),
        .MAX_LEVEL (4'd9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .btn_rot   (btn_rot),
        .next_block(next_block),
        .score_plus(score_plus),
        .gameover  (gameover),
        .block_num (block_num),
        .left      (left),
        .right     (right),
        .down      (down),
        .ro        (ro),
        .score     (score),
        .level     (level),
        .playing   (playing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every request pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (down || left || right || ro != 10'd0)) begin
            mon_obs = {down, ro == 10'd1, left, right};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL req_unexpected: got kind %b at cycle %0d, want none", mon_obs, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.kind != mon_obs) begin
                    bad++;
                    $display("FAIL req_match: got kind %b at cycle %0d, want kind %b at cycle %0d",
                             mon_obs, cyc, mon_e.kind, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input int c, input logic [3:0] k);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    function automatic bit grav_at(input int t);
        return (t > fs) && (((t - fs) % per) == 0);
    endfunction

    // Advance n cycles of FALL, expecting a gravity drop every per cycles after fs.
    task automatic run_fall(input int n);
        int c0;
        c0 = cyc;
        for (int t = c0 + 1; t <= c0 + n; t++)
            if (grav_at(t)) push(t, K_DOWN);
        repeat (n) step();
    endtask

    // Raise the buttons in mask this cycle; requests follow down > rot > left > right,
    // a gravity drop takes its cycle and absorbs a pending down.
    task automatic press(input logic [3:0] mask);
        logic [3:0] pnd;
        int         t;
        {btn_down, btn_rot, btn_left, btn_right} = mask;
        pnd = mask;
        t   = cyc + 1;
        while (pnd != 4'b0000) begin
            if (grav_at(t)) pnd[3] = 1'b0;
            else if (pnd[3]) begin push(t, K_DOWN);  pnd[3] = 1'b0; end
            else if (pnd[2]) begin push(t, K_ROT);   pnd[2] = 1'b0; end
            else if (pnd[1]) begin push(t, K_LEFT);  pnd[1] = 1'b0; end
            else begin              push(t, K_RIGHT); pnd[0] = 1'b0; end
            t++;
        end
    endtask

    task automatic release_all();
        {btn_down, btn_rot, btn_left, btn_right} = 4'b0000;
    endtask

    task automatic drained(input string name);
        sample();
        #1;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        fs  = cyc + 1;
        per = ptab[0];
        sample();
        check("spawn_playing", playing, 1);
        step();
        sample();
        check("fall_playing", playing, 1);
        check("block_range", block_num <= 10'd6, 1);
    endtask

    task automatic land(input logic [9:0] pts, input int new_level);
        next_block = 1'b1;
        score_plus = pts;
        step();
        next_block = 1'b0;
        score_plus = 10'd0;
        fs  = cyc + 1;
        per = ptab[new_level];
        step();
        sample();
        check("land_block_range", block_num <= 10'd6, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_block"},   block_num, 0);
        check({tag, "_left"},    left, 0);
        check({tag, "_right"},   right, 0);
        check({tag, "_down"},    down, 0);
        check({tag, "_ro"},      ro, 0);
        check({tag, "_score"},   score, 0);
        check({tag, "_level"},   level, 0);
        check({tag, "_playing"}, playing, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        next_block = 1'b0;
        gameover = 1'b0;
        score_plus = 10'd0;
        release_all();

        // Reset, then a long idle stretch with no requests.
        repeat (3) step();
        sample();
        check_quiet("reset");
        step();
        rst_n = 1'b1;
        repeat (1000) step();
        sample();
        check_quiet("idle");
        drained("idle_queue");

        // Start and gravity at level 0 (period 10).
        start_game();
        run_fall(35);
        drained("grav_l0_queue");

        // Held button gives one request.
        press(K_LEFT);
        run_fall(50);
        release_all();
        run_fall(5);
        drained("held_left_queue");

        // Left and right together: left, then right.
        press(K_LEFT | K_RIGHT);
        run_fall(6);
        release_all();
        run_fall(3);
        drained("left_right_queue");

        // Button edge coinciding with gravity: down first.
        while (!grav_at(cyc + 1)) run_fall(1);
        press(K_LEFT);
        run_fall(4);
        release_all();
        run_fall(3);
        drained("grav_collide_queue");

        // All four at once: full priority order.
        press(K_DOWN | K_ROT | K_LEFT | K_RIGHT);
        run_fall(8);
        release_all();
        run_fall(3);
        drained("all_four_queue");

        // Landings: score, level, faster gravity.
        land(10'd60, 0);
        check("land1_score", score, 16'd60);
        check("land1_level", level, 4'd0);
        land(10'd60, 1);
        check("land2_score", score, 16'd120);
        check("land2_level", level, 4'd1);
        run_fall(17);
        drained("grav_l1_queue");

        // Gameover beats next_block; nothing issued while over.
        next_block = 1'b1;
        gameover   = 1'b1;
        score_plus = 10'd50;
        step();
        next_block = 1'b0;
        gameover   = 1'b0;
        score_plus = 10'd0;
        sample();
        check("over_playing", playing, 0);
        check("over_score", score, 16'd120);
        check("over_level", level, 4'd1);
        btn_left = 1'b1;
        repeat (30) step();
        start_game();
        check("restart_score", score, 16'd0);
        check("restart_level", level, 4'd0);
        run_fall(12);
        release_all();
        run_fall(2);
        drained("restart_queue");

        // Climb to saturation of level and score.
        for (int i = 1; i <= 64; i++) begin
            land(10'd1023, (i < 9) ? i : 9);
            check("climb_score", score, 32'(1023 * i));
            check("climb_level", level, (i < 9) ? 32'(i) : 32'd9);
        end
        land(10'd48, 9);
        check("score_fff0", score, 16'hFFF0);
        land(10'd100, 9);
        check("score_sat", score, 16'hFFFF);
        check("level_max", level, 4'd9);
        run_fall(10);
        drained("grav_min_queue");
        check("level_hold", level, 4'd9);

        // Asynchronous reset in the middle of play.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        sample();
        check_quiet("post_reset");
        drained("post_reset_queue");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
